gate_equiv_checker: RTL
=======================

Name: gate_equiv_checker

Overview:
- Sequential harness stage wrapped around a pair of combinational gate implementations: one gate-level, one expression-level, built for the same function.
- Upstream: drives every input vector exhaustively onto the shared stimulus bus.
- Downstream: consumes both implementations' outputs, compares them per vector, and counts mismatches.
- Reports the first failing vector and a pass/fail verdict with a start/done handshake. This replaces hand-written #1 stimulus sequences in test modules.

Parameters:
- IN_W, 2, width of the stimulus vector; 2^IN_W vectors per run.
- SETTLE, 1, cycles the stimulus is held before sampling; legal range 1..15.
- CNT_W, IN_W+1, width of the mismatch counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a run; sampled only in IDLE.
- stim  output  IN_W  vector driven to both implementations (x in LSB-1, y in LSB for IN_W=2).
- res_a  input  1  output of implementation A (gate-level).
- res_b  input  1  output of implementation B (expression).
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 when mismatch_cnt==0; valid from done until the next start.
- mismatch_cnt  output  CNT_W  number of vectors where res_a!=res_b; saturates at all-ones.
- fail_valid  output  1  set once the first mismatch is recorded.
- first_fail  output  IN_W  stim value of the first mismatch; 0 if none.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; stim=0, busy=0, done=0, pass=0, mismatch_cnt=0, fail_valid=0, first_fail=0; settle counter=0.
- Reset mid-run: aborts immediately, with no done pulse and all results cleared.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - stim=0.
  - When start=1 at a clock edge: clear mismatch_cnt, fail_valid, first_fail and pass; then go to DRIVE with stim=0 and the settle counter=0.
- DRIVE:
  - stim is held stable.
  - The settle counter increments each cycle.
  - When counter==SETTLE-1, go to SAMPLE next cycle.
  - DRIVE therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle):
  - Compare res_a with res_b, sampled at this edge.
  - On mismatch: mismatch_cnt+1 (hold at max if saturated). If fail_valid==0, set fail_valid=1 and first_fail=stim.
  - If stim==all-ones, go to DONE. Otherwise stim=stim+1, reset the settle counter, and go to DRIVE.
- DONE (one cycle):
  - done=1 and pass=(mismatch_cnt==0), including the update from the final SAMPLE.
  - Next state is IDLE; busy drops with the exit from DONE.
- Timing:
  - Per-vector cost is SETTLE+1 cycles.
  - done is high exactly 1+2^IN_W*(SETTLE+1) cycles after the edge that accepted start. For the defaults this is 9.
- start while busy: ignored; no restart and no queuing.
- start held high through DONE: a new run begins on the first IDLE edge.
- Result retention: results persist in IDLE until the next accepted start.
- stim wrap: stim never wraps inside a run; the terminal vector is detected by an all-ones compare, not by overflow.
- Combinational paths: none from res_a/res_b to any output; all outputs are registered.

Decomposition:
- Shared constants file:
  - State encoding: IDLE=0, DRIVE=1, SAMPLE=2, DONE=3, as 2-bit localparams.
  - SETTLE_MAX=15 and the settle counter width of 4.
- Sub-module settle_timer:
  - Inputs clk, rst_n, clear, enable.
  - Output expire, asserted when count==SETTLE-1.
  - Reused by later harness stages.
- The FSM, stim register and result registers stay in gate_equiv_checker.

Test Plan:
1. Matched pair: res_a and res_b both driven by ~x&~y of stim, IN_W=2, SETTLE=1, start pulse at cycle 0 -> stim steps 0,1,2,3; done at cycle 9; pass=1; mismatch_cnt=0; fail_valid=0; first_fail=0.
2. Fault injection: res_b equals ~x&~y except it is inverted at stim=2 -> pass=0, mismatch_cnt=1, fail_valid=1, first_fail=2'b10.
3. Constant mismatch: res_a=0, res_b=1 -> mismatch_cnt=4, first_fail=0, pass=0; a second run with a matched pair clears the results and gives pass=1.
4. SETTLE=3: stim must hold for 3 cycles per vector, and done must arrive at cycle 17. A glitch that flips res_b during the first two DRIVE cycles of a vector and restores it before the SAMPLE edge must not count as a mismatch.
5. rst_n pulled low at cycle 4 of a run -> all outputs 0 at once, no done pulse; a start after release runs the full sequence normally.
6. start reasserted at cycles 3 and 5 while busy=1 -> the run is unaffected and done occurs only once, at cycle 9.

Source files
------------

// File: rtl/gate_equiv_checker_pkg.sv
// Shared constants for the gate equivalence harness: FSM encoding and settle
// counter sizing.
package gate_equiv_checker_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DRIVE  = ST_DRIVE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } state_e;

  localparam int SETTLE_MAX   = 15;
  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/gate_equiv_checker_settle_timer.sv
// Settle timer: counts enabled cycles since the last clear and flags the
// final cycle of a SETTLE-cycle hold window.
module settle_timer
  import gate_equiv_checker_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_bad_settle
    $error("settle_timer: SETTLE out of range");
  end

  localparam logic [SETTLE_CNT_W-1:0] CNT_LAST = SETTLE_CNT_W'(SETTLE - 1);
  localparam logic [SETTLE_CNT_W-1:0] CNT_ONE  = SETTLE_CNT_W'(1);

  logic [SETTLE_CNT_W-1:0] count_q;
  logic [SETTLE_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == CNT_LAST);

endmodule

// File: rtl/gate_equiv_checker.sv
// Exhaustive equivalence harness: steps every stimulus vector, compares two
// implementations after a settle window, and reports mismatch statistics.
module gate_equiv_checker
  import gate_equiv_checker_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = IN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic             res_a,
  input  logic             res_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             fail_valid,
  output logic [IN_W-1:0]  first_fail
);

  localparam logic [IN_W-1:0]  STIM_LAST = '1;
  localparam logic [IN_W-1:0]  STIM_ONE  = IN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q;
  logic [IN_W-1:0]  stim_q;
  logic [IN_W-1:0]  stim_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] mismatch_cnt_q;
  logic [CNT_W-1:0] mismatch_cnt_d;
  logic             fail_valid_q;
  logic [IN_W-1:0]  first_fail_q;

  logic timer_en;
  logic timer_expire;

  // The timer only runs in DRIVE; every other state holds it at zero so each
  // vector starts a fresh settle window.
  assign timer_en = (state_q == DRIVE);

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!timer_en),
    .enable (timer_en),
    .expire (timer_expire)
  );

  assign stim_d         = stim_q + STIM_ONE;
  assign mismatch_cnt_d = (mismatch_cnt_q == CNT_MAX) ? CNT_MAX
                                                      : mismatch_cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      stim_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      mismatch_cnt_q <= '0;
      fail_valid_q   <= 1'b0;
      first_fail_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          stim_q <= '0;
          if (start) begin
            mismatch_cnt_q <= '0;
            fail_valid_q   <= 1'b0;
            first_fail_q   <= '0;
            pass_q         <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= DRIVE;
          end
        end
        DRIVE: begin
          if (timer_expire) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (res_a != res_b) begin
            mismatch_cnt_q <= mismatch_cnt_d;
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              first_fail_q <= stim_q;
            end
          end
          // Terminal vector is found by compare so stim never wraps to zero.
          if (stim_q == STIM_LAST) begin
            state_q <= DONE;
          end else begin
            stim_q  <= stim_d;
            state_q <= DRIVE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (mismatch_cnt_q == '0);
          busy_q  <= 1'b0;
          stim_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stim         = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign fail_valid   = fail_valid_q;
  assign first_fail   = first_fail_q;

endmodule
